uart_rx_fifo: RTL and testbench

- UART receiver front end for the P_Risc core: the stage directly upstream of the core's serial input path.
- Takes the asynchronous rx pin (ui_in[3] at top level) and synchronises it.
- Deserialises 8N1 frames LSB-first into bytes.
- Buffers received bytes in a small FIFO and presents them to the core over a valid/ready interface.

---
 rtl/uart_rx_fifo.sv | 142 ++++++++++++++
 tb/tb_uart_rx_fifo.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: 2-flop synchronised 8N1 UART receiver feeding a byte FIFO with valid/ready read side.
// Defining UART_RX_PARITY_EN adds an even-parity bit before the stop bit and a parity_err pulse.
module uart_rx_fifo #(
  parameter int CLKS_PER_BIT = 87,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          rx_i,
  output logic [7:0]                    rd_data,
  output logic                          rd_valid,
  input  logic                          rd_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          frame_err,
  output logic                          overrun,
  output logic                          busy
`ifdef UART_RX_PARITY_EN
  ,
  output logic                          parity_err
`endif
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [AW:0] FULL = (AW + 1)'(FIFO_DEPTH);
`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  localparam state_t AFTER_DATA = PARITY;
`else
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  localparam state_t AFTER_DATA = STOP;
`endif
  state_t r_state, w_state_n;
  logic [1:0] r_sync;
  logic r_prev;
  logic [CW-1:0] r_bc, w_bc_n;
  logic [2:0] r_idx, w_idx_n;
  logic [7:0] r_shift, w_shift_n;
  logic [7:0] r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wp, r_rp;
  logic [AW:0] r_cnt;
  logic r_ferr, r_ovr;
  logic w_rxs, w_bit_end, w_stop, w_good, w_full, w_pop, w_wr;
`ifdef UART_RX_PARITY_EN
  logic r_par, w_par_n, r_perr, w_par_bad;
  assign w_par_bad = ^{r_shift, r_par};
  assign w_good = w_stop && w_rxs && !w_par_bad;
  assign parity_err = r_perr;
`else
  assign w_good = w_stop && w_rxs;
`endif
  assign w_rxs = r_sync[1];
  assign w_bit_end = r_bc == LAST;
  assign w_stop = (r_state == STOP) && w_bit_end;
  assign w_full = r_cnt == FULL;
  assign w_pop = rd_valid && rd_ready;
  // a full FIFO still accepts the new byte when the head leaves on the same edge
  assign w_wr = w_good && (!w_full || w_pop);
  assign rd_data = r_mem[r_rp];
  assign rd_valid = r_cnt != '0;
  assign fifo_count = r_cnt;
  assign frame_err = r_ferr;
  assign overrun = r_ovr;
  assign busy = r_state != IDLE;
  always_comb begin
    w_state_n = r_state;
    w_bc_n = r_bc + 1'b1;
    w_idx_n = r_idx;
    w_shift_n = r_shift;
`ifdef UART_RX_PARITY_EN
    w_par_n = r_par;
`endif
    case (r_state)
      IDLE: begin
        w_bc_n = '0;
        w_state_n = (r_prev && !w_rxs) ? START : IDLE;
      end
      START: if (r_bc == HALF) begin
        w_bc_n = '0;
        w_idx_n = '0;
        w_state_n = w_rxs ? IDLE : DATA;
      end
      DATA: if (w_bit_end) begin
        w_bc_n = '0;
        w_shift_n = {w_rxs, r_shift[7:1]};
        w_idx_n = r_idx + 1'b1;
        w_state_n = (r_idx == 3'd7) ? AFTER_DATA : DATA;
      end
`ifdef UART_RX_PARITY_EN
      PARITY: if (w_bit_end) begin
        w_bc_n = '0;
        w_par_n = w_rxs;
        w_state_n = STOP;
      end
`endif
      STOP: if (w_bit_end) begin
        w_bc_n = '0;
        w_state_n = IDLE;
      end
      default: w_state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync <= 2'b11;
      r_prev <= 1'b1;
      r_state <= IDLE;
      r_bc <= '0;
      r_idx <= '0;
      r_shift <= '0;
      r_ferr <= 1'b0;
      r_ovr <= 1'b0;
      r_wp <= '0;
      r_rp <= '0;
      r_cnt <= '0;
`ifdef UART_RX_PARITY_EN
      r_par <= 1'b0;
      r_perr <= 1'b0;
`endif
    end else begin
      r_sync <= {r_sync[0], rx_i};
      r_prev <= w_rxs;
      r_state <= w_state_n;
      r_bc <= w_bc_n;
      r_idx <= w_idx_n;
      r_shift <= w_shift_n;
      r_ferr <= w_stop && !w_rxs;
      r_ovr <= w_good && w_full && !w_pop;
`ifdef UART_RX_PARITY_EN
      r_par <= w_par_n;
      r_perr <= w_stop && w_rxs && w_par_bad;
`endif
      if (w_wr) begin
        r_mem[r_wp] <= r_shift;
        r_wp <= r_wp + 1'b1;
      end
      if (w_pop) r_rp <= r_rp + 1'b1;
      r_cnt <= r_cnt + (AW + 1)'(w_wr) - (AW + 1)'(w_pop);
    end
  end
endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: scenario tasks drive 8N1 frames; a negedge monitor pops expected bytes from a scoreboard.
module tb_uart_rx_fifo;
  logic clk = 1'b0, rst = 1'b1, rx_i = 1'b1, rd_ready = 1'b1;
  logic [7:0] rd_data;
  logic rd_valid, frame_err, overrun, busy;
  logic [2:0] fifo_count;
`ifdef UART_RX_PARITY_EN
  logic parity_err;
`endif
  int n_tests = 0, n_fail = 0, cyc = 0, t0 = 0, first_valid = -1;
  int n_valid = 0, n_ferr = 0, n_ovr = 0;
  logic [7:0] q[$];

  uart_rx_fifo #(.CLKS_PER_BIT(16), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .rx_i(rx_i), .rd_data(rd_data), .rd_valid(rd_valid),
    .rd_ready(rd_ready), .fifo_count(fifo_count), .frame_err(frame_err),
    .overrun(overrun), .busy(busy)
`ifdef UART_RX_PARITY_EN
    , .parity_err(parity_err)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    logic [7:0] exp;
    #1;
    if (rd_valid === 1'b1) begin
      n_valid++;
      if (first_valid < 0) first_valid = cyc;
    end
    if (frame_err === 1'b1) n_ferr++;
    if (overrun === 1'b1) n_ovr++;
    if (rd_valid === 1'b1 && rd_ready === 1'b1) begin
      n_tests++;
      if (q.size() == 0) begin
        n_fail++;
        $display("FAIL rd_pop: got %h while scoreboard empty", rd_data);
      end else begin
        exp = q.pop_front();
        if (rd_data !== exp) begin
          n_fail++;
          $display("FAIL rd_data: got %h want %h", rd_data, exp);
        end
      end
    end
  end

  task automatic send_frame(input logic [7:0] b, input logic stop);
    @(negedge clk);
    t0 = cyc;
    rx_i = 1'b0;
    repeat (16) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx_i = b[i];
      repeat (16) @(negedge clk);
    end
    rx_i = stop;
    repeat (16) @(negedge clk);
    rx_i = 1'b1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_tests++;
    if ({rd_valid, frame_err, overrun, busy} !== 4'b0000 || fifo_count !== 3'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got v%b fe%b ov%b busy%b cnt%0d want all 0",
               rd_valid, frame_err, overrun, busy, fifo_count);
    end
    rst = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_single_byte;
    int v0 = n_valid, f0 = n_ferr, o0 = n_ovr;
    first_valid = -1;
    q.push_back(8'hA5);
    send_frame(8'hA5, 1'b1);
    repeat (4) @(negedge clk);
    n_tests++;
    if (first_valid - t0 < 154 || first_valid - t0 > 156) begin
      n_fail++;
      $display("FAIL single_latency: got %0d want 155+-1", first_valid - t0);
    end
    n_tests++;
    if (n_valid - v0 != 1) begin
      n_fail++;
      $display("FAIL single_valid_cycles: got %0d want 1", n_valid - v0);
    end
    n_tests++;
    if (n_ferr != f0 || n_ovr != o0 || busy !== 1'b0 || q.size() != 0) begin
      n_fail++;
      $display("FAIL single_status: got fe%0d ov%0d busy%b left%0d want 0 0 0 0",
               n_ferr - f0, n_ovr - o0, busy, q.size());
    end
  endtask

  task automatic test_glitch;
    int v0 = n_valid, f0 = n_ferr, o0 = n_ovr;
    @(negedge clk);
    rx_i = 1'b0;
    repeat (3) @(negedge clk);
    n_tests++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL glitch_start: got busy %b want 1", busy);
    end
    @(negedge clk);
    rx_i = 1'b1;
    repeat (12) @(negedge clk);
    n_tests++;
    if (busy !== 1'b0 || n_valid != v0 || n_ferr != f0 || n_ovr != o0) begin
      n_fail++;
      $display("FAIL glitch_idle: got busy%b v%0d fe%0d ov%0d want 0 0 0 0",
               busy, n_valid - v0, n_ferr - f0, n_ovr - o0);
    end
  endtask

  task automatic test_frame_error;
    int f0 = n_ferr, v0 = n_valid;
    send_frame(8'h3C, 1'b0);
    repeat (4) @(negedge clk);
    n_tests++;
    if (n_ferr - f0 != 1 || fifo_count !== 3'd0 || n_valid != v0) begin
      n_fail++;
      $display("FAIL frame_err: got pulses%0d cnt%0d v%0d want 1 0 0",
               n_ferr - f0, fifo_count, n_valid - v0);
    end
    q.push_back(8'h81);
    send_frame(8'h81, 1'b1);
    repeat (4) @(negedge clk);
    n_tests++;
    if (q.size() != 0 || n_ferr - f0 != 1) begin
      n_fail++;
      $display("FAIL frame_recover: got left%0d fe%0d want 0 1", q.size(), n_ferr - f0);
    end
  endtask

  task automatic test_overrun;
    int o0 = n_ovr;
    @(negedge clk);
    rd_ready = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      if (i < 5) q.push_back(8'(i));
      send_frame(8'(i), 1'b1);
      if (i == 4) begin
        n_tests++;
        if (fifo_count !== 3'd4 || n_ovr != o0) begin
          n_fail++;
          $display("FAIL overrun_fill: got cnt%0d ov%0d want 4 0", fifo_count, n_ovr - o0);
        end
      end
    end
    repeat (4) @(negedge clk);
    n_tests++;
    if (fifo_count !== 3'd4 || n_ovr - o0 != 1) begin
      n_fail++;
      $display("FAIL overrun_pulse: got cnt%0d ov%0d want 4 1", fifo_count, n_ovr - o0);
    end
    rd_ready = 1'b1;
    for (int i = 0; i < 50 && q.size() != 0; i++) @(negedge clk);
    repeat (2) @(negedge clk);
    n_tests++;
    if (q.size() != 0 || fifo_count !== 3'd0) begin
      n_fail++;
      $display("FAIL overrun_drain: got left%0d cnt%0d want 0 0", q.size(), fifo_count);
    end
  endtask

  task automatic test_full_pop;
    int o0 = n_ovr;
    @(negedge clk);
    rd_ready = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      q.push_back(8'(i * 8'h11));
      send_frame(8'(i * 8'h11), 1'b1);
    end
    q.push_back(8'h77);
    fork
      send_frame(8'h77, 1'b1);
      begin
        repeat (155) @(negedge clk);
        rd_ready = 1'b1;
        @(negedge clk);
        rd_ready = 1'b0;
      end
    join
    repeat (4) @(negedge clk);
    n_tests++;
    if (fifo_count !== 3'd4 || n_ovr != o0 || q.size() != 4) begin
      n_fail++;
      $display("FAIL full_pop: got cnt%0d ov%0d left%0d want 4 0 4", fifo_count, n_ovr - o0, q.size());
    end
    rd_ready = 1'b1;
    for (int i = 0; i < 50 && q.size() != 0; i++) @(negedge clk);
    repeat (2) @(negedge clk);
    n_tests++;
    if (q.size() != 0 || fifo_count !== 3'd0) begin
      n_fail++;
      $display("FAIL full_pop_drain: got left%0d cnt%0d want 0 0", q.size(), fifo_count);
    end
  endtask

  task automatic test_reset_mid_frame;
    int v0 = n_valid;
    fork
      send_frame(8'hF0, 1'b1);
      begin
        repeat (89) @(negedge clk);
        n_tests++;
        if (busy !== 1'b1) begin
          n_fail++;
          $display("FAIL midrst_busy: got %b want 1", busy);
        end
        rst = 1'b1;
        @(negedge clk);
        n_tests++;
        if ({rd_valid, frame_err, overrun, busy} !== 4'b0000 || fifo_count !== 3'd0) begin
          n_fail++;
          $display("FAIL midrst_outputs: got v%b fe%b ov%b busy%b cnt%0d want all 0",
                   rd_valid, frame_err, overrun, busy, fifo_count);
        end
        rst = 1'b0;
      end
    join
    repeat (20) @(negedge clk);
    n_tests++;
    if (n_valid != v0 || fifo_count !== 3'd0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL midrst_nopush: got v%0d cnt%0d busy%b want 0 0 0", n_valid - v0, fifo_count, busy);
    end
    q.push_back(8'h5A);
    send_frame(8'h5A, 1'b1);
    repeat (4) @(negedge clk);
    n_tests++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL midrst_next: got left%0d want 0", q.size());
    end
  endtask

  task automatic test_back_to_back;
    int f0 = n_ferr, o0 = n_ovr;
    logic [7:0] b;
    for (int i = 0; i < 4; i++) begin
      b = 8'($urandom_range(0, 255));
      q.push_back(b);
      send_frame(b, 1'b1);
    end
    repeat (4) @(negedge clk);
    n_tests++;
    if (q.size() != 0 || n_ferr != f0 || n_ovr != o0) begin
      n_fail++;
      $display("FAIL back_to_back: got left%0d fe%0d ov%0d want 0 0 0", q.size(), n_ferr - f0, n_ovr - o0);
    end
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_glitch();
    test_frame_error();
    test_overrun();
    test_full_pop();
    test_reset_mid_frame();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end
endmodule
